// File: rtl/display_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller: one digit per slot with dead time
// ahead of each anode, and tear-free commit of loaded digits at frame boundaries.
module display_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int TICK_DIV     = 50000,
  parameter int BLANK_CYCLES = 16,
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  output logic [3:0]              nib_out,
  output logic [NUM_DIGITS-1:0]   an_out,
  output logic [IDX_W-1:0]        digit_idx,
  output logic                    frame_done
);

  // state | meaning
  // IDLE  | scan stopped, all anodes dark, digit 0 selected
  // BLANK | dead time at slot start, decoder input settling
  // SHOW  | selected digit's anode on (unless masked)
  typedef enum logic [1:0] {S_IDLE, S_BLANK, S_SHOW} state_t;

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(TICK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] act_data_q, act_data_d, sh_data_q, sh_data_d;
  logic [NUM_DIGITS-1:0]   act_mask_q, act_mask_d, sh_mask_q, sh_mask_d;
  logic                    pend_q, pend_d;
  logic [3:0]              nib_q, nib_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    fd_q, fd_d;
  logic                    wrap;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wrap    = 1'b0;
    if (!enable) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          state_d = S_BLANK;
          cnt_d   = '0;
          idx_d   = '0;
        end
        S_BLANK: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == BLANK_LAST) state_d = S_SHOW;
        end
        S_SHOW: begin
          if (cnt_q == SLOT_LAST) begin
            state_d = S_BLANK;
            cnt_d   = '0;
            if (idx_q == IDX_LAST) begin
              idx_d = '0;
              wrap  = 1'b1;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
          idx_d   = '0;
        end
      endcase
    end
  end

  // A load on the wrap cycle bypasses the shadow so the newest data wins.
  always_comb begin
    sh_data_d  = sh_data_q;
    sh_mask_d  = sh_mask_q;
    act_data_d = act_data_q;
    act_mask_d = act_mask_q;
    pend_d     = pend_q;
    if (load) begin
      sh_data_d = data_in;
      sh_mask_d = blank_mask;
      pend_d    = 1'b1;
    end
    if (wrap) begin
      if (load) begin
        act_data_d = data_in;
        act_mask_d = blank_mask;
      end else if (pend_q) begin
        act_data_d = sh_data_q;
        act_mask_d = sh_mask_q;
      end
      pend_d = 1'b0;
    end else if (state_q == S_IDLE && pend_q) begin
      act_data_d = sh_data_q;
      act_mask_d = sh_mask_q;
      pend_d     = load;
    end
  end

  // Outputs are computed from next-state values so they line up with the state flops.
  always_comb begin
    nib_d = '0;
    an_d  = '1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_d == IDX_W'(k)) begin
        nib_d = act_data_d[4*k +: 4];
        if (state_d == S_SHOW && !act_mask_d[k]) an_d[k] = 1'b0;
      end
    end
    fd_d = (state_d == S_SHOW) && (cnt_d == SLOT_LAST) && (idx_d == IDX_LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      act_data_q <= '0;
      act_mask_q <= '0;
      sh_data_q  <= '0;
      sh_mask_q  <= '0;
      pend_q     <= 1'b0;
      nib_q      <= '0;
      an_q       <= '1;
      fd_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      act_data_q <= act_data_d;
      act_mask_q <= act_mask_d;
      sh_data_q  <= sh_data_d;
      sh_mask_q  <= sh_mask_d;
      pend_q     <= pend_d;
      nib_q      <= nib_d;
      an_q       <= an_d;
      fd_q       <= fd_d;
    end
  end

  assign nib_out    = nib_q;
  assign an_out     = an_q;
  assign digit_idx  = idx_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl: frame-table vectors, hand-written
// corner sequences, and random stimulus against a time-based reference model.
module tb_display_scan_ctrl;
  localparam int ND = 4, TD = 8, BC = 2, FRAME = ND * TD;

  logic        clk = 1'b0;
  logic        rst, enable, load;
  logic [15:0] data_in;
  logic [3:0]  blank_mask;
  logic [3:0]  nib_out, an_out;
  logic [1:0]  digit_idx;
  logic        frame_done;

  int n_cmp = 0, n_err = 0, cyc = 0;
  int pulses[$];

  // Reference model: scan position is just elapsed cycles since the scan started.
  bit          m_run, m_pend;
  int          m_t;
  logic [15:0] m_act, m_sh;
  logic [3:0]  m_actm, m_shm;
  logic [3:0]  e_an, e_nib;
  logic [1:0]  e_idx;
  logic        e_fd;

  typedef struct {
    logic [15:0] data;
    logic [3:0]  mask;
    logic [15:0] ans;
  } vec_t;
  vec_t tbl[4];

  display_scan_ctrl #(.NUM_DIGITS(ND), .TICK_DIV(TD), .BLANK_CYCLES(BC)) dut (
    .clk(clk), .rst(rst), .enable(enable), .load(load), .data_in(data_in),
    .blank_mask(blank_mask), .nib_out(nib_out), .an_out(an_out),
    .digit_idx(digit_idx), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_run = 0; m_pend = 0; m_t = 0;
    m_act = '0; m_sh = '0; m_actm = '0; m_shm = '0;
  endfunction

  function automatic void model_edge();
    bit          wrap, old_pend;
    logic [15:0] old_sh;
    logic [3:0]  old_shm;
    old_sh = m_sh; old_shm = m_shm; old_pend = m_pend;
    wrap = m_run && enable && (m_t % FRAME == FRAME - 1);
    if (load) begin
      m_sh = data_in; m_shm = blank_mask; m_pend = 1;
    end
    if (wrap) begin
      if (load) begin
        m_act = data_in; m_actm = blank_mask;
      end else if (old_pend) begin
        m_act = old_sh; m_actm = old_shm;
      end
      m_pend = 0;
    end else if (!m_run && old_pend) begin
      m_act = old_sh; m_actm = old_shm; m_pend = load;
    end
    if (!enable) begin
      m_run = 0; m_t = 0;
    end else if (!m_run) begin
      m_run = 1; m_t = 0;
    end else begin
      m_t++;
    end
  endfunction

  function automatic void model_out();
    int slot, pos;
    if (!m_run) begin
      e_an = 4'hF; e_idx = 2'd0; e_fd = 1'b0; e_nib = m_act[3:0];
    end else begin
      slot  = (m_t / TD) % ND;
      pos   = m_t % TD;
      e_idx = slot[1:0];
      e_nib = m_act[4*slot +: 4];
      e_an  = (pos >= BC && !m_actm[slot]) ? ~(4'b0001 << slot) : 4'hF;
      e_fd  = (slot == ND - 1) && (pos == TD - 1);
    end
  endfunction

  task automatic step(input bit cmp_model);
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    model_out();
    if (cmp_model) begin
      chk("model_an", 32'(an_out), 32'(e_an));
      chk("model_nib", 32'(nib_out), 32'(e_nib));
      chk("model_idx", 32'(digit_idx), 32'(e_idx));
      chk("model_fd", 32'(frame_done), 32'(e_fd));
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step(1);
  endtask

  task automatic wait_fd();
    int i;
    i = 0;
    while (frame_done !== 1'b1 && i < 2 * FRAME) begin
      step(1);
      i++;
    end
    if (frame_done !== 1'b1) chk("wait_fd_timeout", 32'(frame_done), 32'd1);
  endtask

  initial begin
    logic [15:0] d;
    logic [3:0]  exp_an;
    int          slot, pos;

    tbl[0] = '{16'h1A3F, 4'b0000, 16'h7BDE};
    tbl[1] = '{16'hBEEF, 4'b1100, 16'hFFDE};
    tbl[2] = '{16'h0000, 4'b1111, 16'hFFFF};
    tbl[3] = '{16'h9245, 4'b0101, 16'h7FDF};

    rst = 1'b1; enable = 1'b0; load = 1'b0; data_in = '0; blank_mask = '0;
    model_reset();
    #12;
    chk("reset_an", 32'(an_out), 32'hF);
    chk("reset_nib", 32'(nib_out), 32'h0);
    chk("reset_idx", 32'(digit_idx), 32'h0);
    chk("reset_fd", 32'(frame_done), 32'h0);
    rst = 1'b0;

    // Frame table: load from idle, enable, and check every cycle of the first frame.
    for (int v = 0; v < 4; v++) begin
      enable = 1'b0;
      step(1);
      load = 1'b1; data_in = tbl[v].data; blank_mask = tbl[v].mask;
      step(1);
      load = 1'b0;
      step(1);
      enable = 1'b1;
      d = tbl[v].data;
      for (int c = 0; c < FRAME; c++) begin
        step(1);
        slot = c / TD;
        pos = c % TD;
        exp_an = (pos < BC) ? 4'hF : tbl[v].ans[4*slot +: 4];
        chk("tbl_an", 32'(an_out), 32'(exp_an));
        chk("tbl_nib", 32'(nib_out), 32'(d[4*slot +: 4]));
        chk("tbl_idx", 32'(digit_idx), 32'(slot));
        chk("tbl_fd", 32'(frame_done), (c == FRAME - 1) ? 32'd1 : 32'd0);
      end
    end

    // Free-run: frame_done period and index wrap on the pulse.
    for (int i = 0; i < 5 * FRAME && pulses.size() < 4; i++) begin
      step(1);
      if (frame_done === 1'b1) begin
        pulses.push_back(cyc);
        chk("fd_idx_last", 32'(digit_idx), 32'd3);
        step(1);
        chk("fd_idx_wrap", 32'(digit_idx), 32'd0);
      end
    end
    if (pulses.size() < 4) chk("fd_pulse_count", 32'(pulses.size()), 32'd4);
    else for (int k = 1; k < 4; k++) chk("fd_period", 32'(pulses[k] - pulses[k-1]), 32'(FRAME));

    // Coincident load bypass, then a mid-frame load that must wait for the wrap.
    wait_fd();
    load = 1'b1; data_in = 16'h1A3F; blank_mask = 4'b0000;
    step(1);
    load = 1'b0;
    steps(10);
    load = 1'b1; data_in = 16'hBEEF;
    step(1);
    load = 1'b0;
    steps(8);
    chk("hold_old_slot2", 32'(nib_out), 32'hA);
    wait_fd();
    chk("hold_old_at_fd", 32'(nib_out), 32'h1);
    steps(9);
    chk("new_frame_slot1", 32'(nib_out), 32'hE);

    // Two loads, the later coincident with frame_done: the later one is shown.
    wait_fd();
    steps(29);
    load = 1'b1; data_in = 16'h5555;
    step(1);
    load = 1'b0;
    steps(2);
    chk("coinc_fd", 32'(frame_done), 32'd1);
    load = 1'b1; data_in = 16'hC0DE;
    step(1);
    load = 1'b0;
    chk("coinc_d0", 32'(nib_out), 32'hE);
    steps(8);
    chk("coinc_d1", 32'(nib_out), 32'hD);
    steps(8);
    chk("coinc_d2", 32'(nib_out), 32'h0);
    steps(8);
    chk("coinc_d3", 32'(nib_out), 32'hC);

    // Enable dropped during digit 2 SHOW.
    wait_fd();
    steps(19);
    chk("abort_show_an", 32'(an_out), 32'hB);
    enable = 1'b0;
    step(1);
    chk("abort_an", 32'(an_out), 32'hF);
    chk("abort_idx", 32'(digit_idx), 32'd0);
    chk("abort_fd", 32'(frame_done), 32'd0);
    enable = 1'b1;
    steps(5);

    // Asynchronous reset in the middle of a SHOW clock.
    #2;
    rst = 1'b1;
    #1;
    chk("arst_an", 32'(an_out), 32'hF);
    chk("arst_nib", 32'(nib_out), 32'h0);
    chk("arst_idx", 32'(digit_idx), 32'd0);
    chk("arst_fd", 32'(frame_done), 32'd0);
    model_reset();
    #2;
    rst = 1'b0;
    steps(FRAME + 4);

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      enable     = ($urandom_range(0, 99) != 0);
      load       = ($urandom_range(0, 19) == 0);
      data_in    = 16'($urandom);
      blank_mask = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      step(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
